tff_mod_counter: RTL and testbench

TFF_MOD_COUNTER -- requirements
Module: tff_mod_counter

---
 rtl/tff_mod_counter.sv | 119 +++++++++++
 tb/tb_tff_mod_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tff_mod_counter.sv
// tff_mod_counter
//   Modulo-(MAXVAL+1) up/down counter whose binary state is held in one toggle
//   flip-flop per bit. Each toggle input is cnt XOR next_cnt, so each TFF flips
//   exactly the bits that must change. Parallel load clamps to MAXVAL. The count
//   is presented either in binary or in Gray code. A registered one-cycle pulse
//   flags every wrap step.
//
// Ports
//   clk    : clock; all state changes happen on the rising edge
//   reset  : asynchronous, active-low; clears cnt and tc immediately
//   en     : count enable
//   x      : direction select (0 = up, 1 = down)
//   gray   : output encoding (0 = binary, 1 = Gray); purely combinational on w
//   load   : synchronous parallel load; takes priority over en
//   din    : load value (binary); values above MAXVAL load as MAXVAL
//   w      : encoded count
//   tc     : terminal-count pulse; high for the cycle showing the wrapped value

// Single toggle flip-flop with asynchronous active-low clear.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= 1'b0;
    end else if (t) begin
      q_reg <= ~q_reg;
    end
  end

  assign q = q_reg;

endmodule

module tff_mod_counter #(
  parameter int WIDTH  = 3,
  parameter int MAXVAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             gray,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] w,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAXVAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] toggle;
  logic             tc_reg;
  logic             tc_next;

  // Next-count selection: load beats en, en beats hold. tc_next is only set
  // on a real wrap step; a load that happens to land on a wrap target does
  // not count as a wrap.
  always_comb begin
    cnt_next = cnt;
    tc_next  = 1'b0;
    if (load) begin
      cnt_next = (din > MAX_CNT) ? MAX_CNT : din;
    end else if (en) begin
      if (!x) begin
        if (cnt == MAX_CNT) begin
          cnt_next = '0;
          tc_next  = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end else begin
        if (cnt == '0) begin
          cnt_next = MAX_CNT;
          tc_next  = 1'b1;
        end else begin
          cnt_next = cnt - ONE;
        end
      end
    end
  end

  // Bits that differ between current and next count are the ones to flip.
  assign toggle = cnt ^ cnt_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      tff_cell u_tff (
        .clk   (clk),
        .reset (reset),
        .t     (toggle[gi]),
        .q     (cnt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= tc_next;
    end
  end

  assign tc = tc_reg;

  // Encoding is applied after the state, so switching gray never disturbs cnt.
  assign w = gray ? (cnt ^ (cnt >> 1)) : cnt;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter (WIDTH=4, MAXVAL=10).
// The driver issues one stimulus per cycle on the falling edge and pushes the
// expected post-edge w/tc into a queue; the monitor pops and compares one entry
// after every rising edge. The reference model uses modular arithmetic on an
// integer count.
module tb_tff_mod_counter;

  localparam int WIDTH  = 4;
  localparam int MAXVAL = 10;
  localparam int MOD    = MAXVAL + 1;

  logic             clk;
  logic             reset;
  logic             en;
  logic             x;
  logic             gray;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] w;
  logic             tc;

  tff_mod_counter #(.WIDTH(WIDTH), .MAXVAL(MAXVAL)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .x     (x),
    .gray  (gray),
    .load  (load),
    .din   (din),
    .w     (w),
    .tc    (tc)
  );

  typedef struct {
    int   id;
    int   w;
    bit   tc;
    bit   g;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cnt_m = 0;
  bit   tc_m  = 1'b0;
  int   txn   = 0;
  bit   active = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int enc(input int v, input bit g);
    return g ? (v ^ (v >> 1)) : v;
  endfunction

  function automatic int gray_to_bin(input int gv);
    int b = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      b = b | ((((b >> (i + 1)) & 1) ^ ((gv >> i) & 1)) << i);
    end
    return b;
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // One clock of stimulus: drive on the falling edge, advance the model, queue
  // the value expected after the following rising edge.
  task automatic step(input bit e, input bit xx, input bit g, input bit l,
                      input int d);
    exp_t ex;
    @(negedge clk);
    reset = 1'b1;
    en    = e;
    x     = xx;
    gray  = g;
    load  = l;
    din   = d[WIDTH-1:0];
    if (l) begin
      cnt_m = (d > MAXVAL) ? MAXVAL : d;
      tc_m  = 1'b0;
    end else if (e && !xx) begin
      tc_m  = (cnt_m == MAXVAL);
      cnt_m = (cnt_m + 1) % MOD;
    end else if (e && xx) begin
      tc_m  = (cnt_m == 0);
      cnt_m = (cnt_m + MOD - 1) % MOD;
    end else begin
      tc_m  = 1'b0;
    end
    ex.id = txn++;
    ex.w  = enc(cnt_m, g);
    ex.tc = tc_m;
    ex.g  = g;
    sb_q.push_back(ex);
  endtask

  // Reset asserted between edges with load and en active: outputs must clear
  // before the next rising edge and stay clear through it.
  task automatic reset_pulse();
    exp_t ex;
    @(negedge clk);
    en   = 1'b1;
    load = 1'b1;
    x    = 1'b0;
    din  = WIDTH'($urandom_range(0, 15));
    cnt_m = 0;
    tc_m  = 1'b0;
    ex.id = txn++;
    ex.w  = 0;
    ex.tc = 1'b0;
    ex.g  = gray;
    sb_q.push_back(ex);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_w", int'(w), 0);
    chk("async_reset_tc", int'(tc), 0);
    $display("txn async reset: w=%0d tc=%0d", w, tc);
  endtask

  // Monitor: one pop and compare per rising edge while the driver is active.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          ex = sb_q.pop_front();
          chk("w", int'(w), ex.w);
          chk("tc", int'(tc), int'(ex.tc));
          chk("cnt_le_max", (ex.g ? gray_to_bin(int'(w)) : int'(w)) <= MAXVAL, 1);
          $display("txn %0d: gray=%0d w=%0d tc=%0d (exp w=%0d tc=%0d)",
                   ex.id, ex.g, w, tc, ex.w, ex.tc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    x     = 1'b0;
    gray  = 1'b0;
    load  = 1'b0;
    din   = '0;
    #1 reset = 1'b0;
    #2;
    chk("reset_w", int'(w), 0);
    chk("reset_tc", int'(tc), 0);
    $display("txn reset: w=%0d tc=%0d", w, tc);
    @(posedge clk);
    #1;
    chk("reset_hold_w", int'(w), 0);
    active = 1'b1;

    // Up count through the wrap, binary and Gray.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, i[0], 1'b0, 0);
    // Down count through the wrap.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    // Load clamp, load beats en, load at a down-wrap target clears tc.
    step(1'b0, 1'b0, 1'b0, 1'b1, 15);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, MAXVAL);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Hold with en low, gray toggling over a fixed count.
    step(1'b0, 1'b0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, i[0], 1'b0, 0);
    // Asynchronous reset mid-count, then first edge after release.
    step(1'b1, 1'b0, 1'b0, 1'b1, 4);
    reset_pulse();
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Random run.
    for (int i = 0; i < 2000; i++) begin
      if (i % 701 == 350) reset_pulse();
      else step(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 15)));
    end

    @(posedge clk);
    #3;
    active = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
